// File: rtl/fir_coeff_loader.sv
// Writer side of the FIR coefficient memory: drains the filter, streams FILTER_ORDER
// coefficients into the h port, and hands the port back to the filter control when idle.
module fir_coeff_loader #(
   parameter int SP_WIDTH        = 32,
   parameter int COEFF_EXP_WIDTH = 8,
   parameter int FILTER_ORDER    = 4,
   parameter int MEMORY_DEPTH    = 2 * FILTER_ORDER,
   parameter int ADDRESS_WIDTH   = $clog2(MEMORY_DEPTH),
   parameter int DRAIN_CYCLES    = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     ce_i,
   input  logic                     load_start_i,
   input  logic                     abort_i,
   input  logic [SP_WIDTH-1:0]      coeff_i,
   input  logic                     coeff_valid_i,
   output logic                     coeff_ready_o,
   input  logic                     filt_en_h_i,
   input  logic [ADDRESS_WIDTH-1:0] filt_addr_h_i,
   output logic                     en_h_o,
   output logic                     we_h_o,
   output logic [ADDRESS_WIDTH-1:0] addr_h_o,
   output logic [SP_WIDTH-1:0]      h_o,
   output logic                     filter_ce_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam int DRAIN_CNT_WIDTH = $clog2(DRAIN_CYCLES + 1);
   localparam logic [ADDRESS_WIDTH-1:0]   LAST_BEAT  = ADDRESS_WIDTH'(FILTER_ORDER - 1);
   localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LAST = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     state_nx_s;
   logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_r;
   logic [ADDRESS_WIDTH-1:0]   beat_cnt_r;
   logic                       we_r;
   logic [ADDRESS_WIDTH-1:0]   addr_r;
   logic [SP_WIDTH-1:0]        data_r;
   logic                       done_r;
   logic                       err_r;

   logic is_idle_s;
   logic abortable_s;
   logic write_s;
   logic last_s;
   logic err_set_s;
   logic err_clr_s;

   // Inf and NaN both carry an all-ones exponent field.
   function automatic logic exp_all_ones(input logic [SP_WIDTH-1:0] word);
      exp_all_ones = &word[SP_WIDTH-2 -: COEFF_EXP_WIDTH];
   endfunction

   // Handshake and error decode from the current state.
   always_comb begin
      is_idle_s   = (state_r == ST_IDLE);
      abortable_s = (state_r == ST_DRAIN) || (state_r == ST_LOAD);
      // A beat arriving together with abort is dropped.
      write_s     = (state_r == ST_LOAD) && coeff_valid_i && !abort_i;
      last_s      = write_s && (beat_cnt_r == LAST_BEAT);
      err_clr_s   = is_idle_s && load_start_i;
      err_set_s   = (abortable_s && abort_i) || (write_s && exp_all_ones(coeff_i));
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_start_i) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (abort_i) begin
               state_nx_s = ST_IDLE;
            end else if (drain_cnt_r == DRAIN_LAST) begin
               state_nx_s = ST_LOAD;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         ST_LOAD: begin
            if (abort_i) begin
               state_nx_s = ST_IDLE;
            end else if (last_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Drain counter restarts at zero on every entry into DRAIN.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         drain_cnt_r <= {DRAIN_CNT_WIDTH{1'b0}};
      end else if (state_r != ST_DRAIN) begin
         drain_cnt_r <= {DRAIN_CNT_WIDTH{1'b0}};
      end else begin
         drain_cnt_r <= drain_cnt_r + DRAIN_CNT_WIDTH'(1);
      end
   end

   // Beat counter doubles as the write address for the next accepted coefficient.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         beat_cnt_r <= {ADDRESS_WIDTH{1'b0}};
      end else if (state_r != ST_LOAD) begin
         beat_cnt_r <= {ADDRESS_WIDTH{1'b0}};
      end else if (write_s) begin
         beat_cnt_r <= beat_cnt_r + ADDRESS_WIDTH'(1);
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   // Write registers: each accepted beat reaches the memory port one cycle later.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_r   <= 1'b0;
         addr_r <= {ADDRESS_WIDTH{1'b0}};
         data_r <= {SP_WIDTH{1'b0}};
      end else if (write_s) begin
         we_r   <= 1'b1;
         addr_r <= beat_cnt_r;
         data_r <= coeff_i;
      end else begin
         we_r   <= 1'b0;
         addr_r <= addr_r;
         data_r <= data_r;
      end
   end

   // Completion pulse and sticky error flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         done_r <= last_s;
         if (err_clr_s) begin
            err_r <= 1'b0;
         end else if (err_set_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   // Memory port mux: the filter control owns the port only while idle.
   always_comb begin
      if (is_idle_s) begin
         en_h_o   = filt_en_h_i;
         we_h_o   = 1'b0;
         addr_h_o = filt_addr_h_i;
      end else begin
         en_h_o   = we_r;
         we_h_o   = we_r;
         addr_h_o = addr_r;
      end
      h_o           = data_r;
      coeff_ready_o = (state_r == ST_LOAD);
      busy_o        = !is_idle_s;
      filter_ce_o   = ce_i && is_idle_s;
      done_o        = done_r;
      err_o         = err_r;
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: table-driven loads with a write scoreboard,
// plus hand sequences for drain timing, reset mid-load and the idle pass-through.
module tb_fir_coeff_loader;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ce_i;
   logic        load_start_i;
   logic        abort_i;
   logic [31:0] coeff_i;
   logic        coeff_valid_i;
   logic        coeff_ready_o;
   logic        filt_en_h_i;
   logic [2:0]  filt_addr_h_i;
   logic        en_h_o;
   logic        we_h_o;
   logic [2:0]  addr_h_o;
   logic [31:0] h_o;
   logic        filter_ce_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   fir_coeff_loader dut (
      .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .load_start_i(load_start_i),
      .abort_i(abort_i), .coeff_i(coeff_i), .coeff_valid_i(coeff_valid_i),
      .coeff_ready_o(coeff_ready_o), .filt_en_h_i(filt_en_h_i), .filt_addr_h_i(filt_addr_h_i),
      .en_h_o(en_h_o), .we_h_o(we_h_o), .addr_h_o(addr_h_o), .h_o(h_o),
      .filter_ce_o(filter_ce_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0][31:0] c;
      int               gap;
      int               nb;
      bit               abort;
      bit               exp_err;
      bit               exp_done;
   } vec_t;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [2:0] exp_addr;
   int         n_chk = 0;
   int         n_fail = 0;
   int         wr_count;
   int         done_seen;
   vec_t       vecs[6];

   function automatic vec_t mk(input logic [31:0] c0, input logic [31:0] c1,
                               input logic [31:0] c2, input logic [31:0] c3,
                               input int gap, input int nb, input bit ab,
                               input bit err, input bit done);
      vec_t v;
      v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
      v.gap = gap; v.nb = nb; v.abort = ab; v.exp_err = err; v.exp_done = done;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; predict writes from the handshake now, compare at the next negedge.
   task automatic cycle();
      wr_t e;
      if (coeff_valid_i && coeff_ready_o && !abort_i) begin
         e.addr = exp_addr;
         e.data = coeff_i;
         exp_q.push_back(e);
         exp_addr = exp_addr + 3'd1;
      end
      @(negedge clk_i);
      if (we_h_o || exp_q.size() != 0) begin
         chk("write_present", {63'd0, we_h_o}, {63'd0, exp_q.size() != 0});
         if (we_h_o && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write_addr", {61'd0, addr_h_o}, {61'd0, e.addr});
            chk("write_data", {32'd0, h_o}, {32'd0, e.data});
            wr_count++;
         end else begin
            exp_q.delete();
         end
      end
      if (done_o) begin
         done_seen++;
         chk("done_with_last", {60'd0, we_h_o, addr_h_o}, {60'd0, 1'b1, 3'd3});
      end
      chk("ce_gate", {63'd0, filter_ce_o}, {63'd0, ce_i & ~busy_o});
   endtask

   task automatic run_load(input vec_t v, input int idx);
      int b;
      int gapc;
      int budget;
      bit acc;
      done_seen = 0;
      wr_count  = 0;
      exp_addr  = 3'd0;
      load_start_i  = 1'b1;
      coeff_valid_i = 1'b0;
      cycle();
      load_start_i = 1'b0;
      chk("start_err_clear", {63'd0, err_o}, 64'd0);
      chk("start_busy", {63'd0, busy_o}, 64'd1);
      chk("drain_ready", {63'd0, coeff_ready_o}, 64'd0);
      b = 0; gapc = 0; budget = 0;
      while (b < v.nb && budget < 200) begin
         load_start_i = v.abort;
         if (gapc > 0) begin
            coeff_valid_i = 1'b0;
            gapc--;
         end else begin
            coeff_valid_i = 1'b1;
            coeff_i = v.c[b];
         end
         acc = coeff_valid_i && coeff_ready_o;
         cycle();
         if (acc) begin
            b++;
            gapc = v.gap;
         end
         budget++;
      end
      chk("beats_accepted", 64'(b), 64'(v.nb));
      if (v.abort) begin
         coeff_valid_i = 1'b1;
         coeff_i = v.c[v.nb];
         abort_i = 1'b1;
         cycle();
         abort_i = 1'b0;
      end
      load_start_i  = 1'b0;
      coeff_valid_i = 1'b0;
      repeat (3) cycle();
      chk($sformatf("v%0d_writes", idx), 64'(wr_count), 64'(v.nb));
      chk($sformatf("v%0d_done", idx), 64'(done_seen), 64'(v.exp_done));
      chk($sformatf("v%0d_err", idx), {63'd0, err_o}, {63'd0, v.exp_err});
      chk($sformatf("v%0d_idle", idx), {63'd0, busy_o}, 64'd0);
   endtask

   initial begin
      int n;
      vecs[0] = mk(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000, 0, 4, 1'b0, 1'b0, 1'b1);
      vecs[1] = mk(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000, 2, 4, 1'b0, 1'b0, 1'b1);
      vecs[2] = mk(32'h3F800000, 32'h7FC00000, 32'h3E800000, 32'h3E000000, 0, 4, 1'b0, 1'b1, 1'b1);
      vecs[3] = mk(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000, 0, 2, 1'b1, 1'b1, 1'b0);
      vecs[4] = mk(32'h7F7FFFFF, 32'h80000000, 32'h00800000, 32'h3F800000, 1, 4, 1'b0, 1'b0, 1'b1);
      vecs[5] = mk(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'hFF800000, 1, 4, 1'b0, 1'b1, 1'b1);

      rst_i = 1'b0; ce_i = 1'b1; load_start_i = 1'b0; abort_i = 1'b0;
      coeff_i = 32'd0; coeff_valid_i = 1'b0; filt_en_h_i = 1'b0; filt_addr_h_i = 3'd0;
      exp_addr = 3'd0; wr_count = 0; done_seen = 0;
      #12;
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_ready", {63'd0, coeff_ready_o}, 64'd0);
      chk("rst_we", {63'd0, we_h_o}, 64'd0);
      chk("rst_done_err", {62'd0, done_o, err_o}, 64'd0);
      chk("rst_ce", {63'd0, filter_ce_o}, 64'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      cycle();

      for (int i = 0; i < 6; i++) run_load(vecs[i], i);

      // Drain length: ready rises DRAIN_CYCLES cycles after entering DRAIN; abort in LOAD.
      done_seen = 0; exp_addr = 3'd0;
      load_start_i = 1'b1;
      cycle();
      load_start_i = 1'b0;
      chk("drain_ce_low", {63'd0, filter_ce_o}, 64'd0);
      n = 0;
      while (!coeff_ready_o && n < 50) begin
         cycle();
         n++;
      end
      chk("drain_len", 64'(n), 64'd10);
      abort_i = 1'b1;
      cycle();
      abort_i = 1'b0;
      chk("abort_idle", {63'd0, busy_o}, 64'd0);
      chk("abort_err", {63'd0, err_o}, 64'd1);
      cycle();
      chk("abort_no_done", 64'(done_seen), 64'd0);

      // Reset in the middle of LOAD with err already set by an Inf coefficient.
      exp_addr = 3'd0;
      load_start_i = 1'b1;
      cycle();
      load_start_i = 1'b0;
      n = 0;
      while (!coeff_ready_o && n < 50) begin
         cycle();
         n++;
      end
      coeff_valid_i = 1'b1; coeff_i = 32'h7F800000;
      cycle();
      coeff_i = 32'h3F800000;
      cycle();
      chk("midload_err", {63'd0, err_o}, 64'd1);
      chk("midload_busy", {63'd0, busy_o}, 64'd1);
      rst_i = 1'b0;
      #1;
      chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
      chk("mid_rst_ready", {63'd0, coeff_ready_o}, 64'd0);
      chk("mid_rst_port", {59'd0, en_h_o, we_h_o, addr_h_o}, 64'd0);
      chk("mid_rst_data", {32'd0, h_o}, 64'd0);
      chk("mid_rst_done_err", {62'd0, done_o, err_o}, 64'd0);
      chk("mid_rst_ce", {63'd0, filter_ce_o}, {63'd0, ce_i});
      exp_q.delete();
      coeff_valid_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      cycle();

      // Idle pass-through of the filter read port and ce.
      filt_en_h_i = 1'b1; filt_addr_h_i = 3'd5; ce_i = 1'b0;
      #1;
      chk("pass_en", {63'd0, en_h_o}, 64'd1);
      chk("pass_addr", {61'd0, addr_h_o}, 64'd5);
      chk("pass_we", {63'd0, we_h_o}, 64'd0);
      chk("pass_ce_low", {63'd0, filter_ce_o}, 64'd0);
      ce_i = 1'b1; filt_en_h_i = 1'b0; filt_addr_h_i = 3'd2;
      #1;
      chk("pass_ce_high", {63'd0, filter_ce_o}, 64'd1);
      chk("pass_port2", {59'd0, en_h_o, we_h_o, addr_h_o}, 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
